// File: rtl/hilbert_sched_if.sv
// Handshake and control bundle between the FIR job scheduler and its datapath.
// The scheduler connects through the slave modport; the requester/datapath side uses master.
interface hilbert_sched_if #(
    parameter int AW = 4
);
    logic [1:0]    req;
    logic          flush;
    logic [1:0]    gnt;
    logic [1:0]    x_rd_en;
    logic [AW-1:0] tap_addr;
    logic          rst_SOT;
    logic          ld_term;
    logic          ld_SOT;
    logic          y_valid;
    logic          y_ch;
    logic          busy;

    modport slave (
        input  req, flush,
        output gnt, x_rd_en, tap_addr, rst_SOT, ld_term, ld_SOT, y_valid, y_ch, busy
    );

    modport master (
        output req, flush,
        input  gnt, x_rd_en, tap_addr, rst_SOT, ld_term, ld_SOT, y_valid, y_ch, busy
    );
endinterface

// File: rtl/hilbert_sched.sv
// Two-channel round-robin scheduler that sequences one TAPS-tap FIR job at a time:
// clear the accumulator, stream TAPS samples/coefficients, drain the MAC pipe, report.
module hilbert_sched #(
    parameter int TAPS = 16,
    parameter int AW   = 4
) (
    input  logic           clk,
    input  logic           rst,
    hilbert_sched_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CLR, MAC, DRAIN, DONE} state_t;

    localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);

    state_t        state_q, state_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    x_rd_en_q, x_rd_en_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;
    logic          drain_q, drain_d;
    logic          rst_sot_q, rst_sot_d;
    logic          ld_term_q, ld_term_d;
    logic          ld_sot_q, ld_sot_d;
    logic          y_valid_q, y_valid_d;
    logic          y_ch_q, y_ch_d;
    logic          busy_q, busy_d;
    logic          grant_ch;

    // On a tie the channel that did not win last time goes next.
    assign grant_ch = (bus.req == 2'b11) ? ~last_q : bus.req[1];

    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
        state_d   = state_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        drain_d   = drain_q;
        y_ch_d    = y_ch_q;
        x_rd_en_d = 2'b00;
        rst_sot_d = 1'b0;
        y_valid_d = 1'b0;
        ld_term_d = |x_rd_en_q;
        ld_sot_d  = ld_term_q;

        unique case (state_q)
            IDLE: begin
                if (!bus.flush && (bus.req != 2'b00)) begin
                    state_d   = CLR;
                    gnt_d     = grant_ch ? 2'b10 : 2'b01;
                    last_d    = grant_ch;
                    rst_sot_d = 1'b1;
                    cnt_d     = '0;
                end
            end
            CLR: begin
                state_d   = MAC;
                x_rd_en_d = gnt_q;
            end
            MAC: begin
                if (cnt_q == LAST_TAP) begin
                    state_d = DRAIN;
                    drain_d = 1'b0;
                end else begin
                    cnt_d     = cnt_q + 1'b1;
                    x_rd_en_d = gnt_q;
                end
            end
            DRAIN: begin
                if (drain_q) begin
                    state_d   = DONE;
                    y_valid_d = 1'b1;
                    y_ch_d    = gnt_q[1];
                end else begin
                    drain_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase

        // Abort squashes the whole pipe; last keeps the aborted grant for fairness.
        if ((state_q != IDLE) && bus.flush) begin
            state_d   = IDLE;
            gnt_d     = 2'b00;
            x_rd_en_d = 2'b00;
            rst_sot_d = 1'b0;
            ld_term_d = 1'b0;
            ld_sot_d  = 1'b0;
            y_valid_d = 1'b0;
            cnt_d     = '0;
            drain_d   = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= 2'b00;
            x_rd_en_q <= 2'b00;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            drain_q   <= 1'b0;
            rst_sot_q <= 1'b0;
            ld_term_q <= 1'b0;
            ld_sot_q  <= 1'b0;
            y_valid_q <= 1'b0;
            y_ch_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            x_rd_en_q <= x_rd_en_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            drain_q   <= drain_d;
            rst_sot_q <= rst_sot_d;
            ld_term_q <= ld_term_d;
            ld_sot_q  <= ld_sot_d;
            y_valid_q <= y_valid_d;
            y_ch_q    <= y_ch_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.x_rd_en  = x_rd_en_q;
    assign bus.tap_addr = cnt_q;
    assign bus.rst_SOT  = rst_sot_q;
    assign bus.ld_term  = ld_term_q;
    assign bus.ld_SOT   = ld_sot_q;
    assign bus.y_valid  = y_valid_q;
    assign bus.y_ch     = y_ch_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_hilbert_sched.sv
// Self-checking bench for hilbert_sched: per-cycle job waveform checks plus a
// scoreboard of expected result channels popped whenever y_valid pulses.
module tb_hilbert_sched;
    localparam int TAPS = 16;
    localparam int AW   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    bit   exp_q[$];
    bit   sb_ch;

    hilbert_sched_if #(.AW(AW)) bus ();

    hilbert_sched #(.TAPS(TAPS), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] onehot(input bit ch);
        return ch ? 2'b10 : 2'b01;
    endfunction

    // Scoreboard: every result pulse must match the oldest outstanding job.
    always @(posedge clk) begin
        #1;
        if (bus.y_valid === 1'b1) begin
            check("sb_pop", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                sb_ch = exp_q.pop_front();
                check("y_ch_sb", bus.y_ch, sb_ch);
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_gnt"},     bus.gnt,      0);
        check({tag, "_x_rd_en"}, bus.x_rd_en,  0);
        check({tag, "_tap"},     bus.tap_addr, 0);
        check({tag, "_rst_sot"}, bus.rst_SOT,  0);
        check({tag, "_ld_term"}, bus.ld_term,  0);
        check({tag, "_ld_sot"},  bus.ld_SOT,   0);
        check({tag, "_y_valid"}, bus.y_valid,  0);
        check({tag, "_y_ch"},    bus.y_ch,     0);
        check({tag, "_busy"},    bus.busy,     0);
    endtask

    // Drive req and wait for the grant; returns 1 if it showed up after exp_wait cycles.
    task automatic wait_grant(input logic [1:0] r, input int exp_wait, output bit ok);
        int got;
        got = 0;
        bus.req = r;
        for (int w = 1; w <= 6; w++) begin
            step();
            if (bus.gnt != 2'b00) begin
                got = w;
                break;
            end
        end
        check("gnt_wait", got, exp_wait);
        ok = (got != 0);
    endtask

    // Full job: k=0 is the CLR cycle (gnt first high), k=TAPS+3 is DONE.
    task automatic run_job(input logic [1:0] r, input bit ch, input int exp_wait, input bit drop);
        bit ok;
        exp_q.push_back(ch);
        wait_grant(r, exp_wait, ok);
        if (!ok) return;
        for (int k = 0; k <= TAPS + 3; k++) begin
            check("job_gnt",     bus.gnt, onehot(ch));
            check("job_busy",    bus.busy, 1);
            check("job_rst_sot", bus.rst_SOT, 32'(k == 0));
            check("job_x_rd_en", bus.x_rd_en, (k >= 1 && k <= TAPS) ? onehot(ch) : 2'b00);
            if (k >= 1 && k <= TAPS) check("job_tap_addr", bus.tap_addr, k - 1);
            check("job_ld_term", bus.ld_term, 32'(k >= 2 && k <= TAPS + 1));
            check("job_ld_sot",  bus.ld_SOT,  32'(k >= 3 && k <= TAPS + 2));
            check("job_y_valid", bus.y_valid, 32'(k == TAPS + 3));
            if (k == TAPS + 3) check("job_y_ch", bus.y_ch, ch);
            if (drop && k == 5) bus.req = 2'b00;
            if (k != TAPS + 3) step();
        end
    endtask

    initial begin
        bit ok;
        bus.req   = 2'b00;
        bus.flush = 1'b0;

        #1;
        check_idle_outputs("rst");
        repeat (2) step();
        check_idle_outputs("rst_hold");
        rst = 1'b0;

        // Contention from reset: tie goes to channel 0 first, then alternates.
        run_job(2'b11, 1'b0, 1, 1'b0);
        run_job(2'b11, 1'b1, 2, 1'b0);
        run_job(2'b11, 1'b0, 2, 1'b0);
        bus.req = 2'b00;
        repeat (2) step();
        check("post_rr_busy", bus.busy, 0);

        // Single request on channel 0.
        run_job(2'b01, 1'b0, 1, 1'b0);
        bus.req = 2'b00;
        step();

        // Flush on the 5th MAC cycle: no result, last stays 0 so a tie grants channel 1.
        wait_grant(2'b01, 1, ok);
        if (ok) begin
            check("fl_gnt", bus.gnt, 2'b01);
            bus.req = 2'b00;
            repeat (5) step();
            check("fl_in_mac", bus.x_rd_en, 2'b01);
            bus.flush = 1'b1;
            step();
            bus.flush = 1'b0;
            check("fl_gnt_off",   bus.gnt, 0);
            check("fl_busy_off",  bus.busy, 0);
            check("fl_x_rd_en",   bus.x_rd_en, 0);
            check("fl_ld_term",   bus.ld_term, 0);
            check("fl_ld_sot",    bus.ld_SOT, 0);
            for (int i = 0; i < TAPS + 4; i++) begin
                check("fl_no_y", bus.y_valid, 0);
                step();
            end
        end
        run_job(2'b11, 1'b1, 1, 1'b0);
        bus.req = 2'b00;
        step();

        // Flush in IDLE wins over a pending request.
        bus.req   = 2'b10;
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("idle_fl_gnt",  bus.gnt, 0);
        check("idle_fl_busy", bus.busy, 0);
        run_job(2'b10, 1'b1, 1, 1'b0);
        bus.req = 2'b00;
        step();

        // Request dropped mid-MAC: job finishes, block then stays idle.
        run_job(2'b01, 1'b0, 1, 1'b1);
        repeat (3) begin
            step();
            check("drop_idle_busy", bus.busy, 0);
            check("drop_idle_gnt",  bus.gnt, 0);
        end

        // Async reset between edges in the middle of MAC.
        wait_grant(2'b01, 1, ok);
        if (ok) begin
            repeat (8) step();
            check("ar_in_mac", bus.x_rd_en, 2'b01);
            #3 rst = 1'b1;
            #1;
            check_idle_outputs("async_rst");
            bus.req = 2'b00;
            step();
            rst = 1'b0;
        end else begin
            rst = 1'b0;
        end
        run_job(2'b10, 1'b1, 1, 1'b0);
        bus.req = 2'b00;
        repeat (4) step();

        check("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
